// File: rtl/clkmon_scheduler_pkg.sv
// Project-wide constants shared by the clock-monitor scheduler and the
// frequency counters it sequences.
package clkmon_scheduler_pkg;

   localparam int unsigned SYS_CLOCKFREQ_HZ = 100_000_000;
   localparam int unsigned SYS_BUSW         = 32;

   // Channel-select width, never narrower than one bit.
   function automatic int unsigned addr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clkmon_scheduler_pps_gen.sv
// Free-running strobe generator: one-cycle o_pps on the last count of
// every CLOCKFREQ_HZ-cycle period.
module pps_gen
   import clkmon_scheduler_pkg::*;
#(
   parameter int unsigned CLOCKFREQ_HZ = SYS_CLOCKFREQ_HZ
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_pps
);

   localparam int unsigned   CW   = (CLOCKFREQ_HZ > 1) ? $clog2(CLOCKFREQ_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLOCKFREQ_HZ - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset)          cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
   end

   // Decoded from the counter so it is low while reset holds cnt at 0.
   assign o_pps = (cnt == LAST);

endmodule

// File: rtl/clkmon_scheduler.sv
// Strobes a bank of frequency counters once per period, then scans their
// held counts one channel per cycle against programmed expected values.
module clkmon_scheduler
   import clkmon_scheduler_pkg::*;
#(
   parameter int          NCLK         = 4,
   parameter int          BUSW         = SYS_BUSW,
   parameter int unsigned CLOCKFREQ_HZ = SYS_CLOCKFREQ_HZ,
   parameter int          LGTOL        = 10,
   localparam int         AW           = addr_w(NCLK)
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   output logic                 o_pps,
   input  logic [NCLK*BUSW-1:0] i_counts,
   input  logic                 i_cfg_we,
   input  logic [AW-1:0]        i_cfg_addr,
   input  logic [BUSW-1:0]      i_cfg_data,
   input  logic [AW-1:0]        i_rd_addr,
   output logic [BUSW-1:0]      o_rd_data,
   output logic [NCLK-1:0]      o_valid,
   output logic [NCLK-1:0]      o_fault,
   input  logic [NCLK-1:0]      i_fault_clr,
   output logic                 o_int
);

   // A strobe arriving outside IDLE would be lost, so the period must cover
   // settle + scan + done.
   if (CLOCKFREQ_HZ < NCLK + 4) begin : g_bad_freq
      $error("clkmon_scheduler: CLOCKFREQ_HZ must be >= NCLK+4");
   end

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SCAN, S_DONE} state_t;

   state_t          state, state_nxt;
   logic            settle, settle_nxt;
   logic [AW-1:0]   idx, idx_nxt;
   logic            scan_en;
   logic            first;
   logic            new_fault;

   logic [BUSW-1:0] cnt_arr [NCLK];
   logic [BUSW-1:0] snap    [NCLK];
   logic [BUSW-1:0] expv    [NCLK];

   logic [BUSW-1:0] cur_cnt, cur_exp, cur_tol;
   logic [BUSW:0]   cur_diff;
   logic            cur_bad;

   pps_gen #(.CLOCKFREQ_HZ(CLOCKFREQ_HZ)) u_pps (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_pps   (o_pps)
   );

   always_comb begin
      for (int k = 0; k < NCLK; k++) cnt_arr[k] = i_counts[k*BUSW +: BUSW];
   end

   // Compare in BUSW+1 bits so a count far from expected cannot wrap small.
   always_comb begin
      cur_cnt  = cnt_arr[idx];
      cur_exp  = expv[idx];
      cur_tol  = cur_exp >> LGTOL;
      cur_diff = (cur_cnt >= cur_exp) ? ({1'b0, cur_cnt} - {1'b0, cur_exp})
                                      : ({1'b0, cur_exp} - {1'b0, cur_cnt});
      cur_bad  = (cur_exp != '0) && (cur_diff > {1'b0, cur_tol});
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state  <= S_IDLE;
         settle <= 1'b0;
         idx    <= '0;
      end else begin
         state  <= state_nxt;
         settle <= settle_nxt;
         idx    <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle;
      idx_nxt    = idx;
      scan_en    = 1'b0;
      o_int      = 1'b0;
      case (state)
         S_IDLE: begin
            if (o_pps) begin
               state_nxt  = S_SETTLE;
               settle_nxt = 1'b0;
            end
         end
         S_SETTLE: begin
            if (settle) begin
               state_nxt = S_SCAN;
               idx_nxt   = '0;
            end else begin
               settle_nxt = 1'b1;
            end
         end
         S_SCAN: begin
            scan_en = 1'b1;
            if (idx == AW'(NCLK - 1)) state_nxt = S_DONE;
            else                      idx_nxt   = idx + 1'b1;
         end
         S_DONE: begin
            o_int     = new_fault;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < NCLK; k++) begin
            snap[k] <= '0;
            expv[k] <= '0;
         end
         o_rd_data <= '0;
         o_valid   <= '0;
         o_fault   <= '0;
         first     <= 1'b1;
         new_fault <= 1'b0;
      end else begin
         if (i_cfg_we && (int'(i_cfg_addr) < NCLK)) expv[i_cfg_addr] <= i_cfg_data;

         o_rd_data <= (int'(i_rd_addr) < NCLK) ? snap[i_rd_addr] : '0;

         // Clear first, then a same-cycle set overrides it.
         o_fault <= o_fault & ~i_fault_clr;

         if (state == S_DONE) new_fault <= 1'b0;

         if (scan_en) begin
            if (first) begin
               // Counts from the partial first period are meaningless.
               if (idx == AW'(NCLK - 1)) first <= 1'b0;
            end else begin
               snap[idx]    <= cur_cnt;
               o_valid[idx] <= 1'b1;
               if (cur_bad) begin
                  o_fault[idx] <= 1'b1;
                  if (!o_fault[idx]) new_fault <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_clkmon_scheduler.sv
// Random-stimulus bench for clkmon_scheduler against a cycle-phase model of
// the strobe / scan / fault rules.
module tb_clkmon_scheduler;

   localparam int NCLK  = 4;
   localparam int BUSW  = 32;
   localparam int F     = 100;
   localparam int LGTOL = 4;
   localparam int AW    = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 pps;
   logic [NCLK*BUSW-1:0] counts;
   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic [BUSW-1:0]      cfg_data;
   logic [AW-1:0]        rd_addr;
   logic [BUSW-1:0]      rd_data;
   logic [NCLK-1:0]      valid, fault, fault_clr;
   logic                 irq;

   clkmon_scheduler #(
      .NCLK(NCLK), .BUSW(BUSW), .CLOCKFREQ_HZ(F), .LGTOL(LGTOL)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .o_pps       (pps),
      .i_counts    (counts),
      .i_cfg_we    (cfg_we),
      .i_cfg_addr  (cfg_addr),
      .i_cfg_data  (cfg_data),
      .i_rd_addr   (rd_addr),
      .o_rd_data   (rd_data),
      .o_valid     (valid),
      .o_fault     (fault),
      .i_fault_clr (fault_clr),
      .o_int       (irq)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Reference model: positions in time are measured from the last strobe.
   logic [31:0]     m_exp  [NCLK];
   logic [31:0]     m_snap [NCLK];
   logic [31:0]     cv     [NCLK];
   logic [NCLK-1:0] m_valid, m_fault;
   logic [31:0]     m_rd;
   logic            m_first, m_newf;
   int              c, last_pps, p;
   logic [31:0]     init_exp [NCLK];

   function automatic logic [31:0] pick_count(input logic [31:0] e, input logic [31:0] prev);
      logic [31:0] t;
      t = e >> LGTOL;
      case ($urandom_range(0, 7))
         0:       return e - t - 1;
         1:       return e - t;
         2:       return e + t;
         3:       return e + t + 1;
         4:       return e;
         5:       return e - t + $urandom_range(0, 2 * t);
         6:       return $urandom();
         default: return prev;
      endcase
   endfunction

   function automatic bit out_of_range(input logic [31:0] cnt, input logic [31:0] e);
      longint d;
      d = longint'(cnt) - longint'(e);
      if (d < 0) d = -d;
      return (e != 0) && (d > longint'(e >> LGTOL));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCLK; k++) begin
         m_exp[k]  = '0;
         m_snap[k] = '0;
      end
      m_valid  = '0;
      m_fault  = '0;
      m_rd     = '0;
      m_first  = 1'b1;
      m_newf   = 1'b0;
      c        = 0;
      last_pps = -1;
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      cfg_we    = 1'b0;
      fault_clr = '0;
      repeat (n) begin
         @(posedge clk); #1;
         chk("rst_pps",   pps,     1'b0);
         chk("rst_rd",    rd_data, '0);
         chk("rst_valid", valid,   '0);
         chk("rst_fault", fault,   '0);
         chk("rst_int",   irq,     1'b0);
      end
      model_reset();
      rst = 1'b0;
   endtask

   // Compare outputs after c edges since reset release; sets p for this cycle.
   task automatic check_outputs();
      bit want_pps;
      want_pps = ((c % F) == F - 1);
      if (want_pps) last_pps = c;
      p = (last_pps >= 0) ? c - last_pps : -1;
      chk("pps",   pps,     want_pps);
      chk("rd",    rd_data, m_rd);
      chk("valid", valid,   m_valid);
      chk("fault", fault,   m_fault);
      chk("int",   irq,     (p == NCLK + 3) && m_newf);
   endtask

   task automatic drive_random(input int n);
      for (int k = 0; k < NCLK; k++) cv[k] = pick_count(m_exp[k], cv[k]);
      for (int k = 0; k < NCLK; k++) counts[k*BUSW +: BUSW] = cv[k];
      rd_addr   = AW'($urandom_range(0, NCLK - 1));
      fault_clr = ($urandom_range(0, 7) == 0) ? NCLK'($urandom()) : '0;
      if (n < NCLK) begin
         cfg_we   = 1'b1;
         cfg_addr = AW'(n);
         cfg_data = init_exp[n];
      end else begin
         cfg_we   = ($urandom_range(0, 39) == 0);
         cfg_addr = AW'($urandom_range(0, NCLK - 1));
         case ($urandom_range(0, 3))
            0:       cfg_data = 32'd0;
            1:       cfg_data = 32'd1600;
            2:       cfg_data = 32'd16;
            default: cfg_data = $urandom_range(1, 100000);
         endcase
      end
   endtask

   // Effect of the coming clock edge on the model, from the inputs just driven.
   task automatic model_edge();
      logic [NCLK-1:0] fnext;
      logic [31:0]     new_rd;
      int              k;
      new_rd = m_snap[rd_addr];
      fnext  = m_fault & ~fault_clr;
      if (p >= 3 && p < 3 + NCLK) begin
         k = p - 3;
         if (k == 0) m_newf = 1'b0;
         if (m_first) begin
            if (k == NCLK - 1) m_first = 1'b0;
         end else begin
            m_snap[k]  = cv[k];
            m_valid[k] = 1'b1;
            if (out_of_range(cv[k], m_exp[k])) begin
               if (!m_fault[k]) m_newf = 1'b1;
               fnext[k] = 1'b1;
            end
         end
      end
      m_fault = fnext;
      m_rd    = new_rd;
      if (cfg_we) m_exp[cfg_addr] = cfg_data;
   endtask

   initial begin
      bit mid_done;
      init_exp[0] = 32'd1600;
      init_exp[1] = 32'd1600;
      init_exp[2] = 32'd0;
      init_exp[3] = 32'd16;
      for (int k = 0; k < NCLK; k++) cv[k] = '0;
      counts   = '0;
      cfg_addr = '0;
      cfg_data = '0;
      rd_addr  = '0;
      mid_done = 1'b0;
      do_reset(4);
      for (int n = 0; n < 4000; n++) begin
         check_outputs();
         if (!mid_done && n > 2000 && p == 5) begin
            // Abandon a scan partway through channel 2.
            mid_done = 1'b1;
            do_reset(3);
            continue;
         end
         drive_random(n);
         model_edge();
         @(posedge clk); #1;
         c++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
